// File: rtl/fetchq_pkg.sv
// fetchq_pkg: shared types for the instruction fetch queue.
//   word_t   - 16-bit instruction word / address
//   FQ_DEPTH - default number of queue entries
//   state_t  - fetch FSM states (IDLE, WAIT, DROP)
package fetchq_pkg;
    typedef logic [15:0] word_t;
    localparam int FQ_DEPTH = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;
endpackage

// File: rtl/fetchq_fifo.sv
// fetchq_fifo: circular buffer of {instruction word, address} pairs.
//   clk, reset      - clock, async active-low reset
//   flush_i         - empties the buffer (wins over push/pop)
//   push_i, wdata_i, waddr_i - enqueue a word and its address
//   pop_i           - drop the head entry
//   rdata_o, raddr_o - head word and address (meaningful when count_o != 0)
//   count_o         - number of occupied entries
module fetchq_fifo import fetchq_pkg::*; #(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  word_t                      wdata_i,
    input  word_t                      waddr_i,
    input  logic                       pop_i,
    output word_t                      rdata_o,
    output word_t                      raddr_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    word_t data_q [DEPTH];
    word_t pc_q   [DEPTH];
    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(push_i);
            rd_q    <= rd_q + AW'(pop_i);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            data_q[wr_q] <= wdata_i;
            pc_q[wr_q]   <= waddr_i;
        end
    end
    assign rdata_o = data_q[rd_q];
    assign raddr_o = pc_q[rd_q];
    assign count_o = count_q;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue with a single outstanding memory read.
//   clk, reset           - clock, async active-low reset
//   halt                 - suppresses new memory requests
//   redirect, redirect_pc - flush the queue and restart fetch at redirect_pc
//   mem_req, mem_addr    - read request and its address (held until mem_ack)
//   mem_ack, mem_data    - read completion and returned word
//   ir_valid, ir, ir_pc  - head instruction word and its address
//   deq                  - consumer takes the head
// Build option: FETCHQ_BYPASS_EN forwards an ack straight to ir/ir_pc when
// the queue is empty.
module fetch_queue import fetchq_pkg::*; #(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  halt,
    input  logic  redirect,
    input  word_t redirect_pc,
    output logic  mem_req,
    output word_t mem_addr,
    input  logic  mem_ack,
    input  word_t mem_data,
    output logic  ir_valid,
    output word_t ir,
    output word_t ir_pc,
    input  logic  deq
);
    localparam int CW = $clog2(DEPTH+1);
    state_t state_q, state_d;
    word_t pc_q, pc_d, addr_q, addr_d, head_data, head_pc;
    logic [CW-1:0] count, count_after;
    logic q_valid, bypass, push, pop, issue;
    assign q_valid = count != '0;
`ifdef FETCHQ_BYPASS_EN
    assign bypass = state_q == WAIT && mem_ack && !redirect && !q_valid;
`else
    assign bypass = 1'b0;
`endif
    // A bypassed word that is consumed the same cycle never enters the queue.
    assign push        = state_q == WAIT && mem_ack && !redirect && !(bypass && deq);
    assign pop         = deq && q_valid && !redirect;
    assign count_after = count + CW'(push) - CW'(pop);
    // Issue is gated on entries plus the request being launched fitting in
    // DEPTH, so an ack always has a free slot waiting for it.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect) pc_d = redirect_pc;
                else issue = !halt && count < CW'(DEPTH);
            end
            WAIT: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = mem_ack ? IDLE : DROP;
                end else if (mem_ack) begin
                    issue   = !halt && count_after < CW'(DEPTH);
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (redirect) pc_d = redirect_pc;
                if (mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            state_d = WAIT;
            addr_d  = pc_q;
            pc_d    = pc_q + 16'd1;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end
    fetchq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect),
        .push_i  (push),
        .wdata_i (mem_data),
        .waddr_i (addr_q),
        .pop_i   (pop),
        .rdata_o (head_data),
        .raddr_o (head_pc),
        .count_o (count)
    );
    assign mem_req  = state_q != IDLE;
    assign mem_addr = addr_q;
    assign ir_valid = q_valid || bypass;
    // Outputs read as zero when nothing valid is presented.
    assign ir    = q_valid ? head_data : bypass ? mem_data : '0;
    assign ir_pc = q_valid ? head_pc   : bypass ? addr_q   : '0;
endmodule
